ring_seq_monitor: RTL

Downstream checker for the 4-bit one-hot ring counter (sequence 1 → 2 → 4 → 8 → 1). Samples the counter output every clock and decodes it to a 2-bit position index. Counts completed laps and flags illegal values or out-of-order steps with a sticky error and error code. Feeds status and diagnostics to the lab display and test logic.

---
 rtl/ring_seq_monitor.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ring_seq_monitor.sv
// Checker for a one-hot ring counter (1->2->4->8->1): decodes position, counts laps, flags sequence errors.
// Optional hold-stall detection is enabled by defining RING_MON_STALL_EN.
module ring_seq_monitor #(
    parameter int BITS_COUNT = 4,
    parameter int LAP_W      = 8,
    parameter int STALL_MAX  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [BITS_COUNT-1:0] count_in,
    output logic [1:0]            idx,
    output logic                  idx_valid,
    output logic                  step,
    output logic                  lap_pulse,
    output logic [LAP_W-1:0]      lap_count,
    output logic                  seq_err,
    output logic [1:0]            err_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [BITS_COUNT-1:0] V1 = BITS_COUNT'(1);
    localparam logic [BITS_COUNT-1:0] V2 = BITS_COUNT'(2);
    localparam logic [BITS_COUNT-1:0] V4 = BITS_COUNT'(4);
    localparam logic [BITS_COUNT-1:0] V8 = BITS_COUNT'(8);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_ORDER   = 2'b10;
    localparam logic [1:0] CODE_STALL   = 2'b11;

    // A non-positive stall limit is meaningless; the build keeps the parameter referenced either way.
    if (STALL_MAX < 1) begin : g_stall_max_invalid
    end

    state_t                  state, state_nxt;
    logic [BITS_COUNT-1:0]   prev, prev_nxt;
    logic [1:0]              idx_nxt;
    logic                    idx_valid_nxt;
    logic                    step_nxt;
    logic                    lap_pulse_nxt;
    logic [LAP_W-1:0]        lap_count_nxt;
    logic                    seq_err_nxt;
    logic [1:0]              err_code_nxt;

    logic                    in_legal;
    logic                    in_zero;
    logic [1:0]              in_idx;
    logic [BITS_COUNT-1:0]   prev_next;

`ifdef RING_MON_STALL_EN
    localparam int STALL_W = $clog2(STALL_MAX + 1);
    logic [STALL_W-1:0]      stall_cnt, stall_nxt;
`endif

    assign in_zero  = (count_in == '0);
    assign in_legal = (count_in == V1) || (count_in == V2) ||
                      (count_in == V4) || (count_in == V8);

    always_comb begin
        in_idx = 2'd0;
        case (count_in)
            V2:      in_idx = 2'd1;
            V4:      in_idx = 2'd2;
            V8:      in_idx = 2'd3;
            default: in_idx = 2'd0;
        endcase
    end

    assign prev_next = (prev == V8) ? V1 : (prev << 1);

    always_comb begin
        state_nxt     = state;
        prev_nxt      = count_in;
        idx_nxt       = idx;
        step_nxt      = 1'b0;
        lap_pulse_nxt = 1'b0;
        lap_count_nxt = lap_count;
        err_code_nxt  = err_code;
`ifdef RING_MON_STALL_EN
        stall_nxt     = '0;
`endif
        if (clear) begin
            state_nxt     = IDLE;
            prev_nxt      = '0;
            idx_nxt       = 2'd0;
            lap_count_nxt = '0;
            err_code_nxt  = CODE_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_zero) begin
                        state_nxt = IDLE;
                    end else if (in_legal) begin
                        state_nxt = TRACK;
                        idx_nxt   = in_idx;
                    end else begin
                        state_nxt    = ERR;
                        err_code_nxt = CODE_ILLEGAL;
                    end
                end
                TRACK: begin
                    // Illegal value is checked first so it wins over ordering and stall errors.
                    if (!in_zero && !in_legal) begin
                        state_nxt    = ERR;
                        err_code_nxt = CODE_ILLEGAL;
                    end else if (in_zero) begin
                        state_nxt = IDLE;
                    end else if (count_in == prev) begin
`ifdef RING_MON_STALL_EN
                        if (stall_cnt == STALL_W'(STALL_MAX)) begin
                            state_nxt    = ERR;
                            err_code_nxt = CODE_STALL;
                        end else begin
                            stall_nxt = stall_cnt + 1'b1;
                        end
`else
                        state_nxt = TRACK;
`endif
                    end else if (count_in == prev_next) begin
                        step_nxt = 1'b1;
                        idx_nxt  = in_idx;
                        if (prev == V8) begin
                            lap_pulse_nxt = 1'b1;
                            lap_count_nxt = lap_count + 1'b1;
                        end
                    end else begin
                        state_nxt    = ERR;
                        err_code_nxt = CODE_ORDER;
                    end
                end
                ERR: begin
                    state_nxt = ERR;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        idx_valid_nxt = (state_nxt == TRACK);
        seq_err_nxt   = (state_nxt == ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            idx       <= 2'd0;
            idx_valid <= 1'b0;
            step      <= 1'b0;
            lap_pulse <= 1'b0;
            lap_count <= '0;
            seq_err   <= 1'b0;
            err_code  <= CODE_NONE;
        end else begin
            prev      <= prev_nxt;
            idx       <= idx_nxt;
            idx_valid <= idx_valid_nxt;
            step      <= step_nxt;
            lap_pulse <= lap_pulse_nxt;
            lap_count <= lap_count_nxt;
            seq_err   <= seq_err_nxt;
            err_code  <= err_code_nxt;
        end
    end

`ifdef RING_MON_STALL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_nxt;
        end
    end
`endif

endmodule
